// File: rtl/flash_sample_player.sv
`default_nettype none
// ============================================================================
// Module      : flash_sample_player
// Description : Prefetches one 16-bit sample from the flash reader and plays
//               it out, attenuated, at a fixed tick rate derived from CLOCK_50.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_sample_player #(
    parameter int DIV = 2268
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [15:0] data,
    input  logic        valid,
    output logic        next,
    input  logic        pause,
    input  logic [2:0]  vol,
    output logic [15:0] audio_out,
    output logic        audio_strobe,
    output logic [15:0] underruns
);

    localparam logic [11:0] C_LAST = 12'(DIV - 1);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_ACK    = 2'd1,
        S_SETTLE = 2'd2,
        S_FULL   = 2'd3
    } state_t;

    state_t      r_state;
    logic [11:0] r_cnt;
    logic [15:0] r_buf;
    logic        r_buf_full;
    logic        r_next;
    logic [15:0] r_audio;
    logic        r_strobe;
    logic [15:0] r_underruns;
    logic        w_tick;

    assign w_tick       = (r_cnt == C_LAST) && !pause;
    assign next         = r_next;
    assign audio_out    = r_audio;
    assign audio_strobe = r_strobe;
    assign underruns    = r_underruns;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!pause) begin
            r_cnt <= (r_cnt == C_LAST) ? 12'd0 : r_cnt + 12'd1;
        end
    end

    // Empty buffer at a tick: the codec still gets a strobe and repeats the last sample.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_audio     <= '0;
            r_strobe    <= 1'b0;
            r_underruns <= '0;
        end else begin
            r_strobe <= w_tick;
            if (w_tick && r_buf_full) begin
                r_audio <= $signed(r_buf) >>> vol;
            end else if (w_tick && (r_underruns != 16'hFFFF)) begin
                r_underruns <= r_underruns + 16'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_next     <= 1'b0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else begin
            r_next <= 1'b0;
            if (w_tick && r_buf_full) begin
                r_buf_full <= 1'b0;
            end
            case (r_state)
                S_FETCH: begin
                    if (valid) begin
                        r_state <= S_ACK;
                        r_next  <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_buf      <= data;
                    r_buf_full <= 1'b1;
                    r_state    <= S_SETTLE;
                end
                // The reader still shows valid here; it drops it a cycle after seeing next.
                S_SETTLE: begin
                    r_state <= (w_tick && r_buf_full) ? S_FETCH : S_FULL;
                end
                S_FULL: begin
                    if (w_tick) begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_sample_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_sample_player
// Description : Randomized bench for flash_sample_player against a behavioural
//               model of the prefetch/playout rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_sample_player;

    localparam int C_DIV = 8;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        s_reset  = 1'b1;
    logic [15:0] data     = 16'h0000;
    logic        valid    = 1'b0;
    logic        pause    = 1'b0;
    logic [2:0]  vol      = 3'd0;
    logic        next;
    logic [15:0] audio_out;
    logic        audio_strobe;
    logic [15:0] underruns;
    logic        s_next;
    logic [15:0] s_audio;
    logic        s_strobe;
    logic [15:0] s_under;

    flash_sample_player #(.DIV(C_DIV)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .data(data), .valid(valid), .next(next),
        .pause(pause), .vol(vol), .audio_out(audio_out), .audio_strobe(audio_strobe),
        .underruns(underruns)
    );

    // Permanently starved instance with a one-cycle tick so the counter saturates quickly.
    flash_sample_player #(.DIV(1)) u_starve (
        .CLOCK_50(CLOCK_50), .reset(s_reset), .data(16'h0000), .valid(1'b0), .next(s_next),
        .pause(1'b0), .vol(3'd0), .audio_out(s_audio), .audio_strobe(s_strobe),
        .underruns(s_under)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    int                 m_cnt    = 0;
    logic               m_full   = 1'b0;
    logic               m_ack    = 1'b0;
    logic               m_next   = 1'b0;
    logic               m_strobe = 1'b0;
    logic signed [15:0] m_buf    = '0;
    logic        [15:0] m_out    = '0;
    logic        [15:0] m_under  = '0;
    logic        [15:0] m_s      = '0;
    int                 s_sat    = 0;
    logic               main_chk = 1'b1;

    // Reader model
    int          rd_cnt   = 0;
    int          rd_min   = 20;
    int          rd_max   = 20;
    logic        rd_rand  = 1'b0;
    logic [15:0] rd_fixed = 16'h1234;

    task automatic model_step();
        logic tick;
        logic full0;
        if (reset) begin
            m_cnt = 0; m_full = 1'b0; m_ack = 1'b0; m_next = 1'b0;
            m_strobe = 1'b0; m_out = '0; m_under = '0;
        end else begin
            full0    = m_full;
            tick     = (m_cnt == C_DIV - 1) && !pause;
            m_strobe = tick;
            if (tick && full0) begin
                m_out  = 16'(m_buf >>> vol);
                m_full = 1'b0;
            end else if (tick && m_under != 16'hFFFF) begin
                m_under = m_under + 16'd1;
            end
            if (!pause) m_cnt = (m_cnt == C_DIV - 1) ? 0 : m_cnt + 1;
            m_next = 1'b0;
            if (m_ack) begin
                m_buf  = data;
                m_full = 1'b1;
                m_ack  = 1'b0;
            end else if (!full0 && valid) begin
                m_ack  = 1'b1;
                m_next = 1'b1;
            end
        end
        if (s_reset) m_s = '0;
        else if (m_s != 16'hFFFF) m_s = m_s + 16'd1;
        else s_sat++;
    endtask

    task automatic reader_drive();
        if (next) begin
            valid  = 1'b0;
            rd_cnt = $urandom_range(rd_max, rd_min);
        end else if (!valid) begin
            if (rd_cnt <= 0) begin
                valid = 1'b1;
                data  = rd_rand ? 16'($urandom) : rd_fixed;
            end else begin
                rd_cnt--;
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
        if (main_chk) begin
            check_value("next", 32'(next), 32'(m_next));
            check_value("audio_strobe", 32'(audio_strobe), 32'(m_strobe));
            check_value("audio_out", 32'(audio_out), 32'(m_out));
            check_value("underruns", 32'(underruns), 32'(m_under));
        end
        if (m_s[12:0] == 13'd0 || (m_s >= 16'hFFF0 && s_sat < 24))
            check_value("sat_underruns", 32'(s_under), 32'(m_s));
        reader_drive();
    endtask

    initial begin
        int strobes;
        int guard;
        logic found;
        rd_cnt = 20;
        repeat (3) cycle();
        check_value("reset_next", 32'(next), 32'h0);
        check_value("reset_audio_out", 32'(audio_out), 32'h0);
        check_value("reset_underruns", 32'(underruns), 32'h0);
        reset = 1'b0; s_reset = 1'b0;

        // Fixed 0x1234 stream, latency 20
        repeat (200) cycle();
        check_value("first_sample", 32'(audio_out), 32'h1234);

        // Slow reader: underruns on empty ticks
        rd_min = 40; rd_max = 40; rd_rand = 1'b1;
        repeat (400) cycle();

        // Attenuation extremes
        rd_min = 3; rd_max = 3; rd_rand = 1'b0; rd_fixed = 16'h8000; vol = 3'd7;
        repeat (48) cycle();
        check_value("vol7_min", 32'(audio_out), 32'hFF00);
        rd_fixed = 16'h7FFF; vol = 3'd3;
        repeat (48) cycle();
        check_value("vol3_max", 32'(audio_out), 32'h0FFF);

        // Pause mid-stream
        rd_rand = 1'b1; vol = 3'd0; rd_min = 2; rd_max = 10;
        repeat (13) cycle();
        pause = 1'b1; strobes = 0;
        repeat (100) begin
            cycle();
            strobes += int'(audio_strobe);
        end
        check_value("pause_no_strobes", 32'(strobes), 32'h0);
        pause = 1'b0;
        repeat (100) cycle();

        // Random traffic
        rd_min = 0; rd_max = 25;
        repeat (2000) begin
            cycle();
            if ($urandom_range(0, 63) == 0) pause = ~pause;
            if ($urandom_range(0, 7) == 0) vol = 3'($urandom_range(0, 7));
        end
        pause = 1'b0;

        // Reset landing in the ACK cycle
        found = 1'b0; guard = 0;
        while (!found && guard < 200) begin
            cycle();
            guard++;
            if (next) found = 1'b1;
        end
        check_value("ack_found", 32'(found), 32'h1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_value("ack_reset_next", 32'(next), 32'h0);
        check_value("ack_reset_strobe", 32'(audio_strobe), 32'h0);
        check_value("ack_reset_audio", 32'(audio_out), 32'h0);
        check_value("ack_reset_under", 32'(underruns), 32'h0);
        repeat (300) begin
            cycle();
            if ($urandom_range(0, 7) == 0) vol = 3'($urandom_range(0, 7));
        end

        // Let the starved instance reach and hold saturation
        main_chk = 1'b0; guard = 0;
        while (s_sat < 24 && guard < 70000) begin
            cycle();
            guard++;
        end
        check_value("saturation_reached", 32'(s_sat >= 24), 32'h1);
        check_value("saturation_final", 32'(s_under), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
